// File: rtl/par_to_ser_if.sv
// Word-in / bit-out handshake bundle for par_to_ser.
// master is the environment side, slave is the transmitter side.
interface par_to_ser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] p_x;
    logic             i_valid;
    logic             o_ready;
    logic             o_a;
    logic             o_valid;
    logic             o_last;
    logic             i_ready;

    modport master (
        output p_x, i_valid, i_ready,
        input  o_ready, o_a, o_valid, o_last
    );

    modport slave (
        input  p_x, i_valid, i_ready,
        output o_ready, o_a, o_valid, o_last
    );
endinterface

// File: rtl/par_to_ser.sv
// Parallel-to-serial transmitter: one WIDTH-bit word in, one bit per sink beat out.
// Define PAR_TO_SER_PARITY_EN to append an even-parity bit after the data bits.
module par_to_ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic       i_clk,
    input logic       i_rst_n,
    par_to_ser_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

`ifdef PAR_TO_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             head, at_last, capture, beat;
    logic             ready, valid, a, last;

    assign head    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign at_last = (cnt == LAST_IDX);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        a          = 1'b0;
        last       = 1'b0;
        capture    = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // i_valid is ignored here; only the sink's i_ready paces the bits
                valid = 1'b1;
                a     = head;
                beat  = bus.i_ready;
`ifdef PAR_TO_SER_PARITY_EN
                if (beat && at_last) state_next = PARITY;
`else
                last  = at_last;
                if (beat && at_last) state_next = IDLE;
`endif
            end
`ifdef PAR_TO_SER_PARITY_EN
            PARITY: begin
                valid = 1'b1;
                a     = par;
                last  = 1'b1;
                if (bus.i_ready) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid;
    assign bus.o_a     = a;
    assign bus.o_last  = last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef PAR_TO_SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (capture) begin
                shreg <= bus.p_x;
                cnt   <= '0;
`ifdef PAR_TO_SER_PARITY_EN
                par   <= ^bus.p_x;
`endif
            end else if (beat) begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                // counter saturates at the final index so it never exceeds WIDTH-1
                if (!at_last) cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_par_to_ser.sv
// Directed scoreboard bench for par_to_ser: an LSB-first and an MSB-first instance.
`timescale 1ns/1ps
module tb_par_to_ser;
    localparam int W = 8;
`ifdef PAR_TO_SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    par_to_ser_if #(.WIDTH(W)) b0 ();
    par_to_ser_if #(.WIDTH(W)) b1 ();

    par_to_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
    par_to_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q[$];
    logic s_ov, s_oa, s_ol, s_ordy;
    logic hold_pending, held_a, held_l, first_ov;
    int   tick_no, last_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_ov = b0.o_valid; s_oa = b0.o_a; s_ol = b0.o_last; s_ordy = b0.o_ready;
        end else begin
            s_ov = b1.o_valid; s_oa = b1.o_a; s_ol = b1.o_last; s_ordy = b1.o_ready;
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        sample(sel);
        check({tag, "_ready"}, s_ordy, 1);
        check({tag, "_valid"}, s_ov, 0);
        check({tag, "_a"}, s_oa, 0);
        check({tag, "_last"}, s_ol, 0);
    endtask

    task automatic push_frame(input int sel, input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            logic b;
            b = (sel == 1) ? w[W-1-i] : w[i];
            exp_q.push_back({b, logic'(i == FRAME - 1)});
        end
`ifdef PAR_TO_SER_PARITY_EN
        exp_q.push_back({^w, 1'b1});
`endif
    endtask

    task automatic send(input int sel, input logic [W-1:0] w);
        @(negedge clk);
        if (sel == 0) begin b0.p_x = w; b0.i_valid = 1'b1; b0.i_ready = 1'b0; end
        else          begin b1.p_x = w; b1.i_valid = 1'b1; b1.i_ready = 1'b0; end
        #1;
        sample(sel);
        check("ready_at_capture", s_ordy, 1);
        push_frame(sel, w);
        tick_no = 0; last_tick = 0; hold_pending = 1'b0; first_ov = 1'b0;
    endtask

    task automatic tick(input int sel, input logic rdy, input logic noise);
        logic [1:0] e;
        @(negedge clk);
        if (sel == 0) begin
            b0.i_ready = rdy; b0.i_valid = noise;
            if (noise) b0.p_x = W'($urandom);
        end else begin
            b1.i_ready = rdy; b1.i_valid = noise;
            if (noise) b1.p_x = W'($urandom);
        end
        #1;
        sample(sel);
        tick_no++;
        if (tick_no == 1) first_ov = s_ov;
        if (hold_pending) begin
            check("hold_valid", s_ov, 1);
            check("hold_a", s_oa, held_a);
            check("hold_last", s_ol, held_l);
        end
        if (s_ov && rdy) begin
            if (exp_q.size() == 0) check("unexpected_beat", s_ov, 0);
            else begin
                e = exp_q.pop_front();
                check("bit", s_oa, e[1]);
                check("last", s_ol, e[0]);
                if (s_ol) last_tick = tick_no;
            end
        end
        hold_pending = s_ov && !rdy;
        held_a = s_oa;
        held_l = s_ol;
    endtask

    // toggle=1 drives i_ready 1,0,1,0... starting on the first bit cycle
    task automatic run_frame(input int sel, input logic toggle, input logic noise, input string tag);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++)
            tick(sel, toggle ? logic'((n % 2) == 0) : 1'b1, noise);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_first_valid"}, first_ov, 1);
        check({tag, "_last_cycle"}, last_tick, toggle ? 2 * FRAME - 1 : FRAME);
        tick(sel, 1'b1, 1'b0);
        check({tag, "_ready_after"}, s_ordy, 1);
        check({tag, "_valid_after"}, s_ov, 0);
    endtask

    initial begin
        b0.p_x = '0; b0.i_valid = 1'b0; b0.i_ready = 1'b0;
        b1.p_x = '0; b1.i_valid = 1'b0; b1.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle(0, "rst_lsb");
        check_idle(1, "rst_msb");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle(0, "post_rst");

        // LSB-first A5 at full rate
        send(0, 8'hA5);
        run_frame(0, 1'b0, 1'b0, "a5");

        // back-to-back word right after the idle bubble
        send(0, 8'h5A);
        run_frame(0, 1'b0, 1'b0, "5a");

        // MSB-first 81 with sink stalling every other cycle
        send(1, 8'h81);
        run_frame(1, 1'b1, 1'b0, "81_toggle");

        // junk on p_x/i_valid during SHIFT must not disturb the frame
        send(0, 8'h3C);
        run_frame(0, 1'b0, 1'b1, "noise");
        send(1, 8'hC6);
        run_frame(1, 1'b1, 1'b1, "noise_msb");

        // abort mid-frame
        send(0, 8'hFF);
        repeat (3) tick(0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle(0, "abort");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle(0, "abort_release");
        send(0, 8'h0F);
        run_frame(0, 1'b0, 1'b0, "0f");

`ifdef PAR_TO_SER_PARITY_EN
        send(0, 8'h07);
        run_frame(0, 1'b0, 1'b0, "par07");
        send(0, 8'h03);
        run_frame(0, 1'b1, 1'b0, "par03");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
